ff_fifo_replay_pow2_depth: RTL
==============================

# ff_fifo_replay_pow2_depth

Read-side counterpart of the write-side rollback FIFO: a power-of-two-depth valid/ready FIFO whose consumer can rewind and re-read data it has not yet released. Entries stay in storage after they are delivered until the consumer commits them, so a downstream stage that detects an error can replay from the last commit point. It sits between a producer that never retracts data and a consumer that may need retransmission. This makes it the mirror of the rollback FIFO, where the producer retracts.

## Interface
- D_WIDTH, 6, data width in bits
- A_WIDTH, 3, address width; DEPTH = 2**A_WIDTH entries
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- up_data  in  D_WIDTH  write data
- up_valid  in  1  write request
- up_ready  out  1  FIFO can accept a word
- down_data  out  D_WIDTH  data at the read pointer
- down_valid  out  1  unread data available
- down_ready  in  1  consumer accepts down_data
- down_commit  in  1  release all delivered entries, including a beat handshaken this cycle
- down_replay  in  1  rewind the read pointer to the last commit point
- level  out  A_WIDTH+1  occupied entries (wr_ptr - cm_ptr), 0..DEPTH

## Operation
- Three pointers, each A_WIDTH+1 bits wide with a wrap bit: wr_ptr (write), rd_ptr (speculative read) and cm_ptr (committed read). Pointer arithmetic is modulo 2**(A_WIDTH+1).
- Invariant: cm_ptr ≤ rd_ptr ≤ wr_ptr, measured in modular distance.
- Full when wr_ptr - cm_ptr == DEPTH. up_ready = !full.
- Unread data exists when rd_ptr != wr_ptr. down_valid = (rd_ptr != wr_ptr).
- Write: when up_valid && up_ready, store mem[wr_ptr[A_WIDTH-1:0]] <= up_data and increment wr_ptr.
- Read: down_data = mem[rd_ptr[A_WIDTH-1:0]]. When down_valid && down_ready, increment rd_ptr; call the result rd_next.
- Commit: cm_ptr <= rd_next. A beat delivered in the same cycle is committed with it.
- Replay (down_replay without down_commit): rd_ptr <= cm_ptr.
  - A beat handshaken in the same cycle counts as delivered but is not committed, so it is re-delivered.
- down_commit and down_replay in the same cycle: commit wins and the replay is ignored.
- Replay when rd_ptr == cm_ptr: no effect.
- Commit when rd_ptr == cm_ptr with no handshake: no effect.
- Write and read in the same cycle: both proceed.
  - A write into an empty FIFO is not visible to the read side until the next cycle; there is no bypass.
- A write and a commit in the same cycle when full: the write is refused, because up_ready is computed from the registered pointers. Space freed by the commit is visible the following cycle.
- Flags are derived combinationally from registered pointers only. There is no combinational path from any input to up_ready, down_valid or level.
- The memory array is not reset; its contents after reset are don't-care.

## Timing
- Reset (rst = 0, asynchronous):
  - wr_ptr, rd_ptr, cm_ptr = 0
  - down_valid = 0, up_ready = 1, level = 0
  - down_data is don't-care
- Deassertion of rst is sampled synchronously by the system; the first accepted write may occur in the first cycle with rst = 1.
- Reset asserted mid-operation clears all state immediately, including in-flight replay state. Outputs take their reset values without waiting for a clock edge.
- Latencies:
  - Write to down_valid: 1 cycle.
  - Commit to up_ready / level update: 1 cycle.
  - Replay to rewound down_data: 1 cycle. In the cycle after down_replay, down_data = mem[cm_ptr].
- Throughput: one write and one read per cycle, sustained.
- level changes only on an accepted write (+1) or on a commit (-(rd_next - cm_ptr)). Both can occur in the same cycle.

## Test plan
- Reset: hold rst = 0 for 3 cycles with up_valid = 1 → up_ready = 1, down_valid = 0, level = 0, and no write occurs.
- Fill: with down_ready = 0, write 0x01..0x08 → level = 8 and up_ready = 0 after the 8th write. A 9th word (0x09) offered while full is not accepted, and level stays 8.
- Replay: read 0x01, 0x02, 0x03, then pulse down_replay → the next cycle shows down_data = 0x01 with down_valid = 1, and level = 8. The re-read sequence is 0x01..0x08.
- Commit then replay:
  - Read 0x01..0x03 and pulse down_commit on the 0x03 handshake → next cycle level = 5 and up_ready = 1.
  - Read 0x04, then pulse down_replay → down_data = 0x04.
  - Pulse down_commit and down_replay together after reading 0x04 → level = 4, and the next data is 0x05.
- Wrap-around streaming: push 0x00..0x13 (20 words) with down_ready = 1 and down_commit held high → all words are received in order, with no loss or duplication and no stall. Both pointers wrap twice.
- Mid-operation reset: with level = 5 and rd_ptr 2 ahead of cm_ptr, drop rst between clock edges → outputs return to reset values immediately. Writing 0x2A after release yields down_data = 0x2A one cycle later.

Source files
------------

// File: rtl/ff_fifo_replay_pow2_depth.sv
// Power-of-two valid/ready FIFO whose consumer can rewind to its last commit point.
// Delivered entries stay in storage until the consumer commits them.
module ff_fifo_replay_pow2_depth #(
    parameter int D_WIDTH = 6,
    parameter int A_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready,
    input  logic               down_commit,
    input  logic               down_replay,
    output logic [A_WIDTH:0]   level
);

    localparam int DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] PTR_ONE = (A_WIDTH + 1)'(1);

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH:0]   wr_ptr;
    logic [A_WIDTH:0]   rd_ptr;
    logic [A_WIDTH:0]   cm_ptr;
    logic [A_WIDTH:0]   rd_next;
    logic               full;
    logic               wr_en;
    logic               rd_en;

    // Full when the write pointer is exactly one lap ahead of the committed pointer.
    assign full       = (wr_ptr[A_WIDTH] != cm_ptr[A_WIDTH]) &&
                        (wr_ptr[A_WIDTH-1:0] == cm_ptr[A_WIDTH-1:0]);
    assign up_ready   = !full;
    assign down_valid = (rd_ptr != wr_ptr);
    assign level      = wr_ptr - cm_ptr;
    assign down_data  = mem[rd_ptr[A_WIDTH-1:0]];

    assign wr_en   = up_valid && up_ready;
    assign rd_en   = down_valid && down_ready;
    assign rd_next = rd_en ? (rd_ptr + PTR_ONE) : rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[A_WIDTH-1:0]] <= up_data;
        end
    end

    // Commit takes priority over replay; a beat read during a replay is re-delivered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cm_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (down_commit) begin
                cm_ptr <= rd_next;
                rd_ptr <= rd_next;
            end else if (down_replay) begin
                rd_ptr <= cm_ptr;
            end else begin
                rd_ptr <= rd_next;
            end
        end
    end

endmodule
